gfx_rom_fetch: RTL and testbench
================================

Name: gfx_rom_fetch

Overview:
- Parametrised synchronous fetch controller for graphics ROM banks that run in parallel, such as the K19/K13 tile ROM pair.
- Accepts burst read requests from the tile/layer engine and drives shared active-low CEn/OEn and one address to all banks.
- Waits a programmable access time, then samples the concatenated bank data. Returns one wide word per address, with a valid/ready handshake and a last flag.
- Sits between the tilemap/pixel pipeline and the external or modelled GFX ROMs.

Parameters:
- ADDR_W, 18, ROM word-address width.
- BANK_DW, 16, data width of one ROM bank.
- NUM_BANKS, 2, number of banks read in parallel. Bank 0 drives the MSBs.
- WAIT_CYC, 8, clocks from address-stable/OEn-low until data sampling (ROM access time). Minimum 1.
- LEN_W, 4, width of the burst-length field. Max burst is 2**LEN_W words.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- req_valid, in, 1, burst request valid.
- req_ready, out, 1, controller can accept a request (high only in IDLE).
- req_addr, in, ADDR_W, burst start word address.
- req_len, in, LEN_W, burst length minus 1.
- rd_valid, out, 1, rd_data valid.
- rd_ready, in, 1, consumer accepts rd_data.
- rd_data, out, NUM_BANKS*BANK_DW, sampled concatenated word.
- rd_last, out, 1, final word of the burst.
- busy, out, 1, burst in progress (state != IDLE).
- rom_addr, out, ADDR_W, address to all banks.
- rom_cen, out, 1, active-low chip enable.
- rom_oen, out, 1, active-low output enable.
- rom_data, in, NUM_BANKS*BANK_DW, concatenated bank data.

Behaviour:
- Reset values: state IDLE, req_ready=1, rd_valid=0, rd_last=0, rd_data=0, busy=0, rom_addr=0, rom_cen=1, rom_oen=1, all counters 0. All outputs are registered.
- Reset mid-burst aborts immediately, with no further rd_valid pulses.
- IDLE:
  - rom_cen=1, rom_oen=1, req_ready=1.
  - On req_valid&req_ready, latch addr/len and go to SETUP.
- SETUP (1 clk):
  - rom_addr=current addr, rom_cen=0, rom_oen=1.
  - Address settles with OEn high. Go to ACCESS with wait counter=WAIT_CYC-1.
- ACCESS:
  - rom_cen=0, rom_oen=0.
  - Decrement the counter each clk. At 0, sample rom_data into rd_data, assert rd_valid, and set rd_last=(remaining==0). Go to HOLD.
  - Latency from request acceptance to first rd_valid is 1+WAIT_CYC+1 clocks.
- HOLD:
  - rd_data, rd_valid and rd_last are held stable until rd_ready.
  - rom_oen returns to 1; rom_cen stays 0.
  - On rd_valid&rd_ready:
    - If last: rd_valid=0, go to IDLE (rom_cen=1).
    - Otherwise: addr+1, remaining-1, rd_valid=0, go to SETUP.
  - If rd_ready is already high when rd_valid rises, the word is transferred in that clock.
  - Sustained burst throughput is one word per WAIT_CYC+2 clocks.
- Address wrap: addr+1 wraps modulo 2**ADDR_W (0x3FFFF -> 0x00000 for the default). No error flag.
- Requests are never accepted outside IDLE. req_valid during a burst is ignored until req_ready=1.
- A request can be accepted in the same clock in which the previous burst's last word is accepted? No. IDLE is entered first, so there is at least 1 idle clock between bursts.
- req_len=0 gives a single-word burst with rd_last=1 on the only word.

Decomposition:
- Package gfx_rom_pkg:
  - State enum (IDLE, SETUP, ACCESS, HOLD).
  - DATA_W = NUM_BANKS*BANK_DW localparam helper.
  - Default timing constants.
- One natural sub-module: gfx_rom_wait_cnt, a loadable down-counter with a zero flag, reusable by other ROM/VRAM fetchers.

Test Plan:
1. Reset then idle: hold reset 3 clk -> rom_cen=1, rom_oen=1, rd_valid=0, req_ready=1, rom_addr=0.
2. Single read: req_addr=0x00001, req_len=0, WAIT_CYC=8, rd_ready=1, ROM model returns {K19[1],K13[1]} -> first rd_valid exactly 10 clk after acceptance. rd_data equals the model word and rd_last=1. rom_oen is low for 8 clk only.
3. Burst of 8: req_addr=0x00001, req_len=7 -> 8 words for addresses 1..8 in order, spaced 10 clk apart. rd_last only on address 8. busy falls 1 clk after the last transfer.
4. Back-pressure: rd_ready=0 for 20 clk on word 2 of a 4-word burst -> rd_data and rd_last are stable. rom_addr stays at word 2 and no new SETUP occurs. The burst resumes on rd_ready=1 with no lost or duplicated words.
5. Wrap: req_addr=0x3FFFE, req_len=3 -> addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
6. Reset mid-ACCESS plus a request during busy: a second req_valid mid-burst is not accepted (req_ready=0). Reset asserted in ACCESS -> the next clk shows IDLE outputs with no rd_valid pulse, and a new request afterwards completes normally.

Source files
------------

// File: rtl/gfx_rom_pkg.sv
// Shared types and default timing for the graphics ROM fetch path.
package gfx_rom_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W    = 18;
  localparam int DEF_BANK_DW   = 16;
  localparam int DEF_NUM_BANKS = 2;
  localparam int DEF_WAIT_CYC  = 8;
  localparam int DEF_LEN_W     = 4;
  localparam int DEF_DATA_W    = DEF_NUM_BANKS * DEF_BANK_DW;

  function automatic int data_w(input int num_banks, input int bank_dw);
    return num_banks * bank_dw;
  endfunction

  // Wait counter must be able to hold WAIT_CYC-1; never narrower than 1 bit.
  function automatic int cnt_w(input int wait_cyc);
    return (wait_cyc > 1) ? $clog2(wait_cyc) : 1;
  endfunction

endpackage

// File: rtl/gfx_rom_wait_cnt.sv
// Loadable down-counter with a zero flag; load wins over decrement.
module gfx_rom_wait_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)                    count <= '0;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gfx_rom_fetch.sv
// Burst fetch controller for parallel GFX ROM banks: one shared address and
// CEn/OEn, a programmable access wait, one wide word per address.
module gfx_rom_fetch
  import gfx_rom_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BANK_DW   = DEF_BANK_DW,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int WAIT_CYC  = DEF_WAIT_CYC,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [LEN_W-1:0]             req_len,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [NUM_BANKS*BANK_DW-1:0] rd_data,
  output logic                         rd_last,
  output logic                         busy,
  output logic [ADDR_W-1:0]            rom_addr,
  output logic                         rom_cen,
  output logic                         rom_oen,
  input  logic [NUM_BANKS*BANK_DW-1:0] rom_data
);

  localparam int CNT_W = cnt_w(WAIT_CYC);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYC - 1);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;

  assign cnt_load = (state == SETUP);
  assign cnt_dec  = (state == ACCESS) && !cnt_zero;

  gfx_rom_wait_cnt #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // rom_addr doubles as the burst address register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
      rom_addr  <= '0;
      rom_cen   <= 1'b1;
      rom_oen   <= 1'b1;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            rom_addr  <= req_addr;
            remaining <= req_len;
            rom_cen   <= 1'b0;
            rom_oen   <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          rom_oen <= 1'b0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (cnt_zero) begin
            rd_data  <= rom_data;
            rd_valid <= 1'b1;
            rd_last  <= (remaining == '0);
            rom_oen  <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (rd_last) begin
              rd_last   <= 1'b0;
              rom_cen   <= 1'b1;
              req_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              rom_addr  <= rom_addr + 1'b1;
              remaining <= remaining - 1'b1;
              state     <= SETUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_rom_fetch.sv
// Directed bench for gfx_rom_fetch with a transfer-queue model and a per-cycle monitor.
module tb_gfx_rom_fetch;

  localparam int WAIT = 8;
  localparam int LAT  = WAIT + 2;

  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, rd_ready = 1'b0;
  logic        req_ready, rd_valid, rd_last, busy, rom_cen, rom_oen;
  logic [17:0] req_addr = '0, rom_addr;
  logic [3:0]  req_len = '0;
  logic [31:0] rd_data, rom_data;

  int passed = 0, total = 0, cyc = 0;

  typedef struct {
    logic [17:0] addr;
    logic        last;
  } exp_t;
  exp_t expq[$];

  gfx_rom_fetch #(
    .ADDR_W(18), .BANK_DW(16), .NUM_BANKS(2), .WAIT_CYC(WAIT), .LEN_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .rom_addr(rom_addr), .rom_cen(rom_cen), .rom_oen(rom_oen),
    .rom_data(rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {K19, K13}: bank 0 (K19) in the MSBs.
  function automatic logic [31:0] rom_word(input logic [17:0] a);
    logic [15:0] k19, k13;
    k19 = 16'h1900 + a[15:0];
    k13 = 16'h1300 ^ a[15:0] ^ {14'h0, a[17:16]};
    return {k19, k13};
  endfunction

  assign rom_data = (!rom_cen && !rom_oen) ? rom_word(rom_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: transfer order/data/last, first-word and per-word latency,
  // OEn width, hold stability under back-pressure.
  logic        p_valid = 1'b0, p_ready = 1'b0, p_oen = 1'b1, p_last = 1'b0;
  logic [31:0] p_data = '0;
  logic [17:0] p_addr = '0;
  int          oen_run = 0, due = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      expq.delete();
      p_valid = 1'b0; p_oen = 1'b1; oen_run = 0;
    end else begin
      chk("ready_vs_busy", 64'(req_ready), 64'(!busy));
      if (!rom_oen) begin
        oen_run++;
        chk("oen_needs_cen", 64'(rom_cen), 64'(0));
        chk("oen_in_burst", 64'(expq.size() > 0), 64'(1));
        if (expq.size() > 0) chk("rom_addr", 64'(rom_addr), 64'(expq[0].addr));
      end else if (!p_oen) begin
        chk("oen_width", 64'(oen_run), 64'(WAIT));
        oen_run = 0;
      end
      if (rd_valid && !p_valid) begin
        chk("valid_expected", 64'(expq.size() > 0), 64'(1));
        chk("valid_latency", 64'(cyc), 64'(due));
      end
      if (p_valid && !p_ready) begin
        chk("hold_valid", 64'(rd_valid), 64'(1));
        chk("hold_data", 64'(rd_data), 64'(p_data));
        chk("hold_last", 64'(rd_last), 64'(p_last));
        chk("hold_addr", 64'(rom_addr), 64'(p_addr));
      end
      if (rd_valid && rd_ready && expq.size() > 0) begin
        e = expq.pop_front();
        chk("model_data", 64'(rd_data), 64'(rom_word(e.addr)));
        chk("model_last", 64'(rd_last), 64'(e.last));
        due = cyc + LAT;
      end
      if (req_valid && req_ready) begin
        for (int i = 0; i <= int'(req_len); i++)
          expq.push_back('{addr: 18'(req_addr + 18'(i)), last: (i == int'(req_len))});
        due = cyc + LAT;
      end
      p_valid = rd_valid; p_ready = rd_ready; p_data = rd_data;
      p_last  = rd_last;  p_addr  = rom_addr; p_oen  = rom_oen;
    end
  end

  task automatic do_req(input logic [17:0] a, input logic [3:0] l, output int tacc);
    int n = 0;
    @(posedge clk); #1;
    req_addr = a; req_len = l; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_accept", 64'(req_ready), 64'(1));
    tacc = cyc;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic get_word(output logic [31:0] d, output logic l, output int t);
    int n = 0;
    @(negedge clk);
    while (!(rd_valid && rd_ready) && n < 200) begin @(negedge clk); n++; end
    chk("word_arrives", 64'(rd_valid && rd_ready), 64'(1));
    d = rd_data; l = rd_last; t = cyc;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        l;
    int          ta, t, tp, n;
    logic [31:0] wrap_tab[4];
    wrap_tab[0] = 32'h18FE_ECFD; wrap_tab[1] = 32'h18FF_ECFC;
    wrap_tab[2] = 32'h1900_1300; wrap_tab[3] = 32'h1901_1301;

    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cen", 64'(rom_cen), 64'(1));
    chk("rst_oen", 64'(rom_oen), 64'(1));
    chk("rst_valid", 64'(rd_valid), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_addr", 64'(rom_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_data", 64'(rd_data), 64'(0));
    chk("rst_last", 64'(rd_last), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    rd_ready = 1'b1;

    // 2: single read
    do_req(18'h00001, 4'd0, ta);
    get_word(d, l, t);
    chk("single_latency", 64'(t - ta), 64'(10));
    chk("single_data", 64'(d), 64'h1901_1301);
    chk("single_last", 64'(l), 64'(1));
    @(negedge clk);
    chk("single_busy_after", 64'(busy), 64'(0));

    // 3: burst of 8
    do_req(18'h00001, 4'd7, ta);
    tp = ta;
    for (int i = 1; i <= 8; i++) begin
      get_word(d, l, t);
      chk("burst_data", 64'(d), 64'(32'h1900_1300 | {16'(i), 16'(i)}));
      chk("burst_last", 64'(l), 64'(i == 8));
      chk("burst_spacing", 64'(t - tp), 64'(10));
      tp = t;
    end
    @(negedge clk);
    chk("burst_busy_after", 64'(busy), 64'(0));

    // 4: back-pressure on word 2 of a 4-word burst
    do_req(18'h00010, 4'd3, ta);
    get_word(d, l, t);
    chk("bp_w0", 64'(d), 64'h1910_1310);
    rd_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rd_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_w1_valid", 64'(rd_valid), 64'(1));
    repeat (20) @(negedge clk);
    chk("bp_stall_data", 64'(rd_data), 64'h1911_1311);
    chk("bp_stall_last", 64'(rd_last), 64'(0));
    chk("bp_stall_addr", 64'(rom_addr), 64'h00011);
    chk("bp_stall_oen", 64'(rom_oen), 64'(1));
    chk("bp_stall_cen", 64'(rom_cen), 64'(0));
    @(posedge clk); #1 rd_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      get_word(d, l, t);
      chk("bp_data", 64'(d), 64'(32'h1910_1310 | {16'(i), 16'(i)}));
      chk("bp_last", 64'(l), 64'(i == 3));
    end

    // 5: address wrap
    do_req(18'h3FFFE, 4'd3, ta);
    for (int i = 0; i < 4; i++) begin
      get_word(d, l, t);
      chk("wrap_data", 64'(d), 64'(wrap_tab[i]));
      chk("wrap_last", 64'(l), 64'(i == 3));
    end

    // 6: request during busy is ignored, reset in ACCESS aborts the burst
    do_req(18'h00020, 4'd3, ta);
    repeat (3) @(posedge clk);
    #1 req_addr = 18'h00777; req_len = 4'd1; req_valid = 1'b1;
    @(negedge clk);
    chk("busy_no_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    chk("busy_no_ready2", 64'(req_ready), 64'(0));
    chk("busy_in_access", 64'(rom_oen), 64'(0));
    @(posedge clk); #1 req_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", 64'(rd_valid), 64'(0));
    chk("abort_cen", 64'(rom_cen), 64'(1));
    chk("abort_oen", 64'(rom_oen), 64'(1));
    chk("abort_ready", 64'(req_ready), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_addr", 64'(rom_addr), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    repeat (15) begin
      @(negedge clk);
      chk("abort_quiet", 64'(rd_valid), 64'(0));
    end
    do_req(18'h00005, 4'd0, ta);
    get_word(d, l, t);
    chk("post_rst_latency", 64'(t - ta), 64'(10));
    chk("post_rst_data", 64'(d), 64'h1905_1305);
    chk("post_rst_last", 64'(l), 64'(1));
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
